if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address loaded into the PC on reset.
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 le_pc  input  1  PC load enable from hazard unit; 0 = stall PC.
REQ-006 le_ifid  input  1  IF/ID load enable from hazard unit; 0 = hold IF/ID.
REQ-007 br_taken  input  1  branch/BL resolved taken this cycle.
REQ-008 br_target  input  32  branch target address.
REQ-009 rom_addr  output  8  combinational instruction ROM address (byte index).
REQ-010 rom_instr  input  32  instruction word returned combinationally by the ROM.
REQ-011 pc_out  output  32  current PC register.
REQ-012 ifid_instr  output  32  IF/ID instruction register.
REQ-013 ifid_pc4  output  32  IF/ID copy of fetch PC + 4.
REQ-014 ifid_valid  output  1  IF/ID holds a real fetched instruction.
REQ-015 fetch_count  output  CNT_W  instructions loaded into IF/ID since reset.
REQ-016 stall_count  output  CNT_W  cycles the PC was stalled in RUN.

Function
REQ-017 The block SHALL implement a two-state FSM: BOOT, RUN.
REQ-018 BOOT SHALL last exactly one cycle after reset release, then go to RUN unconditionally; RUN SHALL persist until reset.
REQ-019 In BOOT, PC, IF/ID and counters SHALL hold their reset values regardless of inputs.
REQ-020 rom_addr SHALL equal pc_out[7:0] at all times (wraps modulo 256).
REQ-021 In RUN, priority SHALL be br_taken > le_pc/le_ifid.
REQ-022 br_taken=1: PC <= br_target; IF/ID <= {NOP_INSTR, 32'h0}, ifid_valid <= 0, irrespective of le_pc/le_ifid.
REQ-023 br_taken=0, le_pc=1: PC <= PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 br_taken=0, le_ifid=1: ifid_instr <= rom_instr, ifid_pc4 <= PC + 4, ifid_valid <= 1.
REQ-025 le_pc=0 / le_ifid=0 (no branch): the corresponding register SHALL hold its value; the enables are independent.
REQ-026 fetch_count SHALL increment when REQ-024 loads IF/ID; stall_count SHALL increment each RUN cycle with le_pc=0 and br_taken=0.
REQ-027 Both counters SHALL saturate at all-ones, never wrap.
REQ-028 Latency: an instruction at address A SHALL appear on ifid_instr one cycle after pc_out=A with le_ifid=1.

Reset
REQ-029 Asserting reset SHALL immediately set: state=BOOT, pc_out=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0, both counters=0.
REQ-030 Reset asserted mid-operation (including during a branch or stall) SHALL override all other inputs with the values of REQ-029.

Structure
REQ-031 NOP_INSTR (32'h0000_0000), PC_STEP (4) and the FSM state encoding SHALL reside in the shared CPU package.
REQ-032 A sub-module sat_counter (parameterised width, inc, async active-low reset) SHALL be instantiated twice for the counters; the PC and IF/ID registers stay inline.

Verification
REQ-033 Reset release, le_pc=le_ifid=1, ROM[0..3]=distinct words -> cycle 1 BOOT (pc_out=0, valid=0); then pc_out 0,4,8; ifid_instr=ROM[0] with ifid_pc4=4 one cycle after pc_out=0.
REQ-034 Stall: le_pc=le_ifid=0 for 3 cycles at pc_out=8 -> pc_out and IF/ID held, stall_count +3, fetch_count unchanged.
REQ-035 Branch during stall: br_taken=1, br_target=32'h40, le_pc=0 -> next cycle pc_out=32'h40, ifid_instr=0, ifid_valid=0, stall_count unchanged.
REQ-036 Wrap: branch to 32'hFFFF_FFFC then run -> pc_out 32'hFFFF_FFFC then 0; rom_addr 8'hFC then 8'h00.
REQ-037 Saturation: CNT_W=4, 20 stall cycles -> stall_count stays 4'hF.
REQ-038 Async reset asserted mid-cycle while pc_out=32'h40 -> outputs reach REQ-029 values before the next clock edge.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared CPU definitions for the fetch stage: the NOP encoding, the PC step and
// the fetch FSM state type.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_stage_sat_counter.sv
// Saturating up-counter: counts up on inc and then holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (inc && !(&count_reg)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, and fetch/stall
// performance counters. A single BOOT cycle after reset release, then RUN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             le_pc,
    input  logic             le_ifid,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic [7:0]       rom_addr,
    input  logic [31:0]      rom_instr,
    output logic [31:0]      pc_out,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  ifid_instr_reg;
    logic [31:0]  ifid_pc4_reg;
    logic         ifid_valid_reg;
    logic [31:0]  pc_plus4;
    logic         run;

    assign pc_plus4 = pc_reg + PC_STEP;
    assign run      = (state_reg == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= BOOT;
            pc_reg         <= RESET_PC;
            ifid_instr_reg <= NOP_INSTR;
            ifid_pc4_reg   <= 32'h0;
            ifid_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: state_reg <= RUN;
                RUN: begin
                    // A taken branch flushes IF/ID and wins over any hazard stall.
                    if (br_taken) begin
                        pc_reg         <= br_target;
                        ifid_instr_reg <= NOP_INSTR;
                        ifid_pc4_reg   <= 32'h0;
                        ifid_valid_reg <= 1'b0;
                    end else begin
                        if (le_pc) begin
                            pc_reg <= pc_plus4;
                        end
                        if (le_ifid) begin
                            ifid_instr_reg <= rom_instr;
                            ifid_pc4_reg   <= pc_plus4;
                            ifid_valid_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= BOOT;
            endcase
        end
    end

    // Counter 0 tracks IF/ID loads, counter 1 tracks PC stall cycles.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = run && !br_taken && le_ifid;
    assign cnt_inc[1] = run && !br_taken && !le_pc;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign rom_addr    = pc_reg[7:0];
    assign pc_out      = pc_reg;
    assign ifid_instr  = ifid_instr_reg;
    assign ifid_pc4    = ifid_pc4_reg;
    assign ifid_valid  = ifid_valid_reg;
    assign fetch_count = cnt_val[0];
    assign stall_count = cnt_val[1];

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage with a cycle-level behavioural model;
// uses a 4-bit counter width so saturation is reached often.
module tb_if_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          le_pc = 1'b0;
    logic          le_ifid = 1'b0;
    logic          br_taken = 1'b0;
    logic [31:0]   br_target = 32'h0;
    logic [7:0]    rom_addr;
    logic [31:0]   rom_instr;
    logic [31:0]   pc_out;
    logic [31:0]   ifid_instr;
    logic [31:0]   ifid_pc4;
    logic          ifid_valid;
    logic [CW-1:0] fetch_count;
    logic [CW-1:0] stall_count;

    logic [31:0] rom_mem [64];

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .le_pc       (le_pc),
        .le_ifid     (le_ifid),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .rom_addr    (rom_addr),
        .rom_instr   (rom_instr),
        .pc_out      (pc_out),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );

    assign rom_instr = rom_mem[rom_addr[7:2]];

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        int          fetch;
        int          stall;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_boot;
    int          m_fetch, m_stall;
    int          sat_max = (1 << CW) - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_fetch = 0; m_stall = 0; m_boot = 1'b1;
    endfunction

    function automatic void push_exp(input string tag);
        exp_t e;
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
        e.fetch = m_fetch; e.stall = m_stall; e.tag = tag;
        exp_q.push_back(e);
    endfunction

    // One clock of stimulus: drive inputs, advance the model, queue its prediction.
    task automatic step(input logic br, input logic [31:0] tgt, input logic lp,
                        input logic li, input string tag);
        logic [31:0] cur_word;
        @(negedge clk);
        reset = 1'b1; br_taken = br; br_target = tgt; le_pc = lp; le_ifid = li;
        cur_word = rom_mem[m_pc[7:2]];
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (br) begin
            m_pc = tgt; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            if (li) begin
                m_instr = cur_word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                if (m_fetch < sat_max) m_fetch++;
            end
            if (!lp) begin
                if (m_stall < sat_max) m_stall++;
            end
            if (lp) m_pc = m_pc + 32'd4;
        end
        push_exp(tag);
        $display("step %-6s br=%0b tgt=%h le_pc=%0b le_ifid=%0b -> exp pc=%h instr=%h pc4=%h v=%0b f=%0d s=%0d",
                 tag, br, tgt, lp, li, m_pc, m_instr, m_pc4, m_valid, m_fetch, m_stall);
    endtask

    task automatic hold_reset(input string tag);
        @(negedge clk);
        reset = 1'b0; br_taken = $urandom_range(0, 1); le_pc = $urandom_range(0, 1);
        le_ifid = $urandom_range(0, 1); br_target = $urandom;
        model_reset();
        push_exp(tag);
        $display("step %-6s reset held", tag);
    endtask

    // Assert reset between edges and require outputs to clear before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_pc", pc_out, 32'h0);
        check("async_instr", ifid_instr, 32'h0);
        check("async_pc4", ifid_pc4, 32'h0);
        check("async_valid", {31'h0, ifid_valid}, 32'h0);
        check("async_fetch", 32'(fetch_count), 32'h0);
        check("async_stall", 32'(stall_count), 32'h0);
        check("async_romaddr", {24'h0, rom_addr}, 32'h0);
        $display("async reset at %0t", $time);
        model_reset();
        push_exp("arst");
        hold_reset("rsthld");
    endtask

    // Monitor: compare DUT state just after each rising edge against the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_pc"}, pc_out, e.pc);
                check({e.tag, "_romaddr"}, {24'h0, rom_addr}, {24'h0, e.pc[7:0]});
                check({e.tag, "_instr"}, ifid_instr, e.instr);
                check({e.tag, "_pc4"}, ifid_pc4, e.pc4);
                check({e.tag, "_valid"}, {31'h0, ifid_valid}, {31'h0, e.valid});
                check({e.tag, "_fetch"}, 32'(fetch_count), 32'(e.fetch));
                check({e.tag, "_stall"}, 32'(stall_count), 32'(e.stall));
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
        rom_mem[0] = 32'hA000_0001; rom_mem[1] = 32'hB000_0002;
        rom_mem[2] = 32'hC000_0003; rom_mem[3] = 32'hD000_0004;
        model_reset();
        #1;
        check("por_pc", pc_out, 32'h0);
        check("por_valid", {31'h0, ifid_valid}, 32'h0);
        hold_reset("rst");
        hold_reset("rst");

        // Boot then straight-line fetch
        step(1'b0, 32'h0, 1'b1, 1'b1, "boot");
        step(1'b0, 32'h0, 1'b1, 1'b1, "run");
        step(1'b0, 32'h0, 1'b1, 1'b1, "run");
        // Full stall at pc 8, then branch while stalled
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, "stall");
        step(1'b1, 32'h40, 1'b0, 1'b0, "brstl");
        async_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1, "boot");
        // Wrap from the top of the address space
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, "brtop");
        step(1'b0, 32'h0, 1'b1, 1'b1, "wrap");
        step(1'b0, 32'h0, 1'b1, 1'b1, "wrap");
        // Long stall drives stall_count into saturation; independent enables
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0, "satst");
        step(1'b0, 32'h0, 1'b1, 1'b0, "pconly");
        step(1'b0, 32'h0, 1'b0, 1'b1, "ifonly");
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1, "satft");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end else begin
                t = ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 8'($urandom) & 8'hFC};
                step(($urandom_range(0, 7) == 0), t, ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) != 0), "rand");
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
